// File: rtl/clock_divider_pkg.sv
// rtl/clock_divider_pkg.sv - shared types and defaults for the programmable clock divider
package clock_divider_pkg;

    localparam int DEF_CNT_W     = 16;
    localparam int DEF_RESET_DIV = 12;
    localparam int MIN_DIV       = 2;

    typedef enum logic {
        PH_LOW  = 1'b0,
        PH_HIGH = 1'b1
    } phase_t;

endpackage

// File: rtl/clock_divider_ratio_reg.sv
// rtl/clock_divider_ratio_reg.sv - pending/current divide ratio with legality check
module clock_divider_ratio_reg
    import clock_divider_pkg::*;
#(
    parameter int CNT_W     = DEF_CNT_W,
    parameter int RESET_DIV = DEF_RESET_DIV
) (
    input  logic             clk_in,
    input  logic             rst,
    input  logic [CNT_W-1:0] div_val,
    input  logic             div_load,
    input  logic             boundary,
    output logic [CNT_W-1:0] cur_div,
    output logic             div_busy,
    output logic             div_err
);

    logic [CNT_W-1:0] pend_q, pend_d;
    logic [CNT_W-1:0] cur_q, cur_d;
    logic             busy_q, busy_d;
    logic             err_q, err_d;
    logic             legal;

    assign legal = div_val >= CNT_W'(MIN_DIV);

    // The boundary consumes the old pending value before a coincident load replaces it.
    always_comb begin
        pend_d = pend_q;
        cur_d  = cur_q;
        busy_d = busy_q;
        err_d  = div_load && !legal;
        if (boundary && busy_q) begin
            cur_d  = pend_q;
            busy_d = 1'b0;
        end
        if (div_load && legal) begin
            pend_d = div_val;
            busy_d = 1'b1;
        end
    end

    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            pend_q <= CNT_W'(RESET_DIV);
            cur_q  <= CNT_W'(RESET_DIV);
            busy_q <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            pend_q <= pend_d;
            cur_q  <= cur_d;
            busy_q <= busy_d;
            err_q  <= err_d;
        end
    end

    assign cur_div  = cur_q;
    assign div_busy = busy_q;
    assign div_err  = err_q;

endmodule

// File: rtl/clock_divider_prog.sv
// rtl/clock_divider_prog.sv - programmable clock divider: period counter and phase FSM
module clock_divider_prog
    import clock_divider_pkg::*;
#(
    parameter int CNT_W     = DEF_CNT_W,
    parameter int RESET_DIV = DEF_RESET_DIV
) (
    input  logic             clk_in,
    input  logic             rst,
    input  logic             en,
    input  logic [CNT_W-1:0] div_val,
    input  logic             div_load,
    output logic             div_busy,
    output logic             div_err,
    output logic [CNT_W-1:0] cur_div,
    output logic             clk_out,
    output logic             tick
);

    phase_t           phase_q, phase_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             started_q, started_d;
    logic             clk_out_q, clk_out_d;
    logic             tick_q, tick_d;
    logic             boundary;
    logic [CNT_W-1:0] half_n;

    assign half_n = cur_div - (cur_div >> 1);

    clock_divider_ratio_reg #(
        .CNT_W     (CNT_W),
        .RESET_DIV (RESET_DIV)
    ) u_ratio (
        .clk_in   (clk_in),
        .rst      (rst),
        .div_val  (div_val),
        .div_load (div_load),
        .boundary (boundary),
        .cur_div  (cur_div),
        .div_busy (div_busy),
        .div_err  (div_err)
    );

    // The first enabled edge after reset is treated as a period boundary entering PH_HIGH.
    always_comb begin
        phase_d   = phase_q;
        cnt_d     = cnt_q;
        started_d = started_q;
        tick_d    = 1'b0;
        boundary  = 1'b0;
        if (en) begin
            if (!started_q) begin
                started_d = 1'b1;
                phase_d   = PH_HIGH;
                cnt_d     = '0;
                tick_d    = 1'b1;
                boundary  = 1'b1;
            end else begin
                case (phase_q)
                    PH_HIGH: begin
                        cnt_d = cnt_q + CNT_W'(1);
                        if (cnt_q == half_n - CNT_W'(1)) begin
                            phase_d = PH_LOW;
                        end
                    end
                    default: begin
                        if (cnt_q == cur_div - CNT_W'(1)) begin
                            cnt_d    = '0;
                            phase_d  = PH_HIGH;
                            tick_d   = 1'b1;
                            boundary = 1'b1;
                        end else begin
                            cnt_d = cnt_q + CNT_W'(1);
                        end
                    end
                endcase
            end
        end
        clk_out_d = (phase_d == PH_HIGH);
    end

    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            phase_q   <= PH_LOW;
            cnt_q     <= '0;
            started_q <= 1'b0;
            clk_out_q <= 1'b0;
            tick_q    <= 1'b0;
        end else begin
            phase_q   <= phase_d;
            cnt_q     <= cnt_d;
            started_q <= started_d;
            clk_out_q <= clk_out_d;
            tick_q    <= tick_d;
        end
    end

    assign clk_out = clk_out_q;
    assign tick    = tick_q;

endmodule

// File: tb/tb_clock_divider_prog.sv
// tb/tb_clock_divider_prog.sv - self-checking bench for clock_divider_prog
module tb_clock_divider_prog;

    localparam int W = 4;

    logic         clk_in = 1'b0;
    logic         rst = 1'b1;
    logic         en = 1'b0;
    logic [W-1:0] div_val = '0;
    logic         div_load = 1'b0;
    logic         div_busy, div_err, clk_out, tick;
    logic [W-1:0] cur_div;

    int vectors = 0;
    int miscompares = 0;
    bit chk_en = 1'b0;

    // Reference: position within the period, the ratio in force and the pending ratio.
    bit m_started = 1'b0;
    int m_pos = 0;
    int m_n = 12;
    int m_pend = 12;
    bit m_busy = 1'b0;
    bit m_err = 1'b0;
    bit m_tick = 1'b0;
    bit m_bnd = 1'b0;

    clock_divider_prog #(.CNT_W(W), .RESET_DIV(12)) dut (
        .clk_in   (clk_in),
        .rst      (rst),
        .en       (en),
        .div_val  (div_val),
        .div_load (div_load),
        .div_busy (div_busy),
        .div_err  (div_err),
        .cur_div  (cur_div),
        .clk_out  (clk_out),
        .tick     (tick)
    );

    always #5 clk_in = ~clk_in;

    task automatic chk(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge clk_in or posedge rst) begin
        if (rst) begin
            m_started = 1'b0; m_pos = 0; m_n = 12; m_pend = 12;
            m_busy = 1'b0; m_err = 1'b0; m_tick = 1'b0;
        end else begin
            m_bnd = 1'b0;
            m_tick = 1'b0;
            if (en) begin
                if (!m_started) begin
                    m_started = 1'b1; m_pos = 0; m_tick = 1'b1; m_bnd = 1'b1;
                end else begin
                    m_pos++;
                    if (m_pos == m_n) begin
                        m_pos = 0; m_tick = 1'b1; m_bnd = 1'b1;
                    end
                end
            end
            if (m_bnd && m_busy) begin
                m_n = m_pend;
                m_busy = 1'b0;
            end
            m_err = div_load && (int'(div_val) < 2);
            if (div_load && int'(div_val) >= 2) begin
                m_pend = int'(div_val);
                m_busy = 1'b1;
            end
        end
    end

    always @(negedge clk_in) begin
        if (chk_en) begin
            chk("model_clk_out", int'(clk_out), int'(m_started && (m_pos < m_n - m_n / 2)));
            chk("model_tick", int'(tick), int'(m_tick));
            chk("model_busy", int'(div_busy), int'(m_busy));
            chk("model_err", int'(div_err), int'(m_err));
            chk("model_cur_div", int'(cur_div), m_n);
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk_in);
        #2;
    endtask

    task automatic load(input int v);
        div_load = 1'b1;
        div_val = W'(v);
        cyc(1);
        div_load = 1'b0;
    endtask

    task automatic wait_busy_clear();
        for (int i = 0; i < 40 && div_busy; i++) @(negedge clk_in);
        chk("busy_wait", int'(div_busy), 0);
    endtask

    task automatic wait_tick();
        for (int i = 0; i < 40; i++) begin
            @(negedge clk_in);
            if (tick) break;
        end
        chk("tick_wait", int'(tick), 1);
    endtask

    task automatic sample(input int n, output logic [23:0] p, output int ticks);
        p = {23'd0, clk_out};
        ticks = int'(tick);
        for (int i = 1; i < n; i++) begin
            @(negedge clk_in);
            p = {p[22:0], clk_out};
            ticks += int'(tick);
        end
    endtask

    int tv_n[3] = '{15, 2, 3};
    int tv_p[3] = '{32'h7F80, 32'b10, 32'b110};

    initial begin
        logic [23:0] pat;
        int nt;

        cyc(2);
        chk_en = 1'b1;
        @(negedge clk_in);
        chk("rst_clk_out", int'(clk_out), 0);
        chk("rst_cur_div", int'(cur_div), 12);
        chk("rst_busy", int'(div_busy), 0);

        // Default ratio 12: 6 high / 6 low, first tick on the first edge after release.
        cyc(1);
        rst = 1'b0;
        en = 1'b1;
        @(posedge clk_in);
        @(negedge clk_in);
        sample(24, pat, nt);
        chk("n12_pattern", int'(pat), 32'hFC0FC0);
        chk("n12_ticks", nt, 2);

        // Ratio 5 loaded mid-period: applied at the boundary as 3 high / 2 low.
        cyc(3);
        load(5);
        chk("n5_busy", int'(div_busy), 1);
        wait_busy_clear();
        chk("n5_cur_div", int'(cur_div), 5);
        sample(10, pat, nt);
        chk("n5_pattern", int'(pat), 32'b1110011100);

        // Illegal ratios 1 and 0.
        div_load = 1'b1;
        div_val = W'(1);
        cyc(1);
        div_val = W'(0);
        @(negedge clk_in);
        chk("err_first", int'(div_err), 1);
        cyc(1);
        div_load = 1'b0;
        @(negedge clk_in);
        chk("err_second", int'(div_err), 1);
        chk("err_cur_div", int'(cur_div), 5);
        chk("err_busy", int'(div_busy), 0);
        cyc(1);
        @(negedge clk_in);
        chk("err_cleared", int'(div_err), 0);

        // 7 then 9 inside one period: only 9 takes effect.
        wait_tick();
        cyc(1);
        load(7);
        load(9);
        wait_busy_clear();
        chk("n9_cur_div", int'(cur_div), 9);
        sample(9, pat, nt);
        chk("n9_pattern", int'(pat), 32'b111110000);

        // Load coincident with a boundary waits one full period.
        wait_tick();
        cyc(8);
        load(4);
        @(negedge clk_in);
        chk("coinc_cur_div_old", int'(cur_div), 9);
        chk("coinc_busy", int'(div_busy), 1);
        wait_tick();
        chk("coinc_cur_div_new", int'(cur_div), 4);

        // Freeze for 10 cycles inside PH_HIGH of N=4.
        cyc(1);
        en = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk_in);
            chk("frz_clk_out", int'(clk_out), 1);
            chk("frz_tick", int'(tick), 0);
        end
        @(posedge clk_in);
        #2;
        en = 1'b1;
        @(negedge clk_in);
        @(negedge clk_in);
        sample(4, pat, nt);
        chk("frz_resume", int'(pat), 32'b0011);
        chk("frz_resume_tick", nt, 1);

        // Reset with pending ratio 3 while cnt = 4 of N = 6.
        cyc(1);
        load(6);
        wait_busy_clear();
        cyc(1);
        load(3);
        cyc(2);
        chk("pre_rst_busy", int'(div_busy), 1);
        rst = 1'b1;
        @(negedge clk_in);
        chk("arst_clk_out", int'(clk_out), 0);
        chk("arst_tick", int'(tick), 0);
        chk("arst_busy", int'(div_busy), 0);
        chk("arst_cur_div", int'(cur_div), 12);
        cyc(2);
        rst = 1'b0;
        @(posedge clk_in);
        @(negedge clk_in);
        chk("rel_tick", int'(tick), 1);
        chk("rel_clk_out", int'(clk_out), 1);
        chk("rel_cur_div", int'(cur_div), 12);

        // Extreme ratios including the largest representable one.
        for (int k = 0; k < 3; k++) begin
            cyc(1);
            load(tv_n[k]);
            wait_busy_clear();
            sample(tv_n[k], pat, nt);
            chk($sformatf("tbl_pattern_%0d", tv_n[k]), int'(pat), tv_p[k]);
            chk($sformatf("tbl_ticks_%0d", tv_n[k]), nt, 1);
        end

        // Mixed enable and load activity, checked by the reference only.
        for (int i = 0; i < 300; i++) begin
            en = ($urandom_range(0, 3) != 0);
            div_load = ($urandom_range(0, 9) == 0);
            div_val = W'($urandom_range(0, 15));
            cyc(1);
        end
        en = 1'b1;
        div_load = 1'b0;
        cyc(5);
        @(negedge clk_in);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
